q_pipe_fifo: RTL and testbench

Clocked, parametrised four-phase (return-to-zero) handshake pipeline with a WIDTH-bit datapath and DEPTH-entry elastic buffer. Bridges an upstream r_in/a_in producer to a downstream r_out/a_out consumer on a single local clock. It is the generalised successor of the single-bit two-step Q-flop stage, adding data, depth, occupancy status and protocol-error detection.

---
 rtl/q_pipe_fifo.sv | 229 ++++++++++++++++++++++
 tb/tb_q_pipe_fifo.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_pipe_fifo.sv
// Four-phase (return-to-zero) handshake pipeline with a DEPTH-entry elastic buffer.
// Define Q_PIPE_SYNC_EN to put SYNC_STAGES-deep synchronisers on r_in and a_out.
module q_pipe_fifo #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       r_in,
   input  logic [WIDTH-1:0]           d_in,
   output logic                       a_in,
   output logic                       r_out,
   output logic [WIDTH-1:0]           d_out,
   input  logic                       a_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [0:0] {
      IN_IDLE = 1'b0,
      IN_ACK  = 1'b1
   } in_state_t;

   typedef enum logic [1:0] {
      OUT_IDLE = 2'b00,
      OUT_REQ  = 2'b01,
      OUT_RTZ  = 2'b10
   } out_state_t;

   if ((WIDTH < 1) || (WIDTH > 64) || (DEPTH < 2) || (DEPTH > 256) ||
       ((DEPTH & (DEPTH - 1)) != 0) || (SYNC_STAGES < 2) || (SYNC_STAGES > 3)) begin : g_bad_params
      $error("q_pipe_fifo: illegal parameter set");
   end

   logic             r_in_s;
   logic             a_out_s;

   in_state_t        in_state_r;
   in_state_t        in_next_s;
   out_state_t       out_state_r;
   out_state_t       out_next_s;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             a_in_r;
   logic             a_in_nxt_s;
   logic             r_out_r;
   logic             r_out_nxt_s;
   logic [WIDTH-1:0] d_out_r;
   logic             err_r;

   logic             push_s;
   logic             pop_s;
   logic             launch_s;
   logic             err_set_s;

`ifdef Q_PIPE_SYNC_EN
   logic [SYNC_STAGES-1:0] r_in_sync_r;
   logic [SYNC_STAGES-1:0] a_out_sync_r;

   // Synchroniser chains for the request and acknowledge coming from other domains
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_in_sync_r  <= '0;
         a_out_sync_r <= '0;
      end else begin
         r_in_sync_r  <= {r_in_sync_r[SYNC_STAGES-2:0], r_in};
         a_out_sync_r <= {a_out_sync_r[SYNC_STAGES-2:0], a_out};
      end
   end

   assign r_in_s  = r_in_sync_r[SYNC_STAGES-1];
   assign a_out_s = a_out_sync_r[SYNC_STAGES-1];
`else
   assign r_in_s  = r_in;
   assign a_out_s = a_out;
`endif

   // Input handshake: accept one item per request, stall while the buffer is full
   always_comb begin
      in_next_s  = in_state_r;
      push_s     = 1'b0;
      a_in_nxt_s = a_in_r;
      case (in_state_r)
         IN_IDLE: begin
            if (r_in_s && !full_r) begin
               push_s     = 1'b1;
               a_in_nxt_s = 1'b1;
               in_next_s  = IN_ACK;
            end else begin
               a_in_nxt_s = 1'b0;
            end
         end
         IN_ACK: begin
            if (!r_in_s) begin
               a_in_nxt_s = 1'b0;
               in_next_s  = IN_IDLE;
            end else begin
               a_in_nxt_s = 1'b1;
            end
         end
         default: begin
            a_in_nxt_s = 1'b0;
            in_next_s  = IN_IDLE;
         end
      endcase
   end

   // Output handshake: present head item, pop on acknowledge, wait for return-to-zero
   always_comb begin
      out_next_s  = out_state_r;
      pop_s       = 1'b0;
      launch_s    = 1'b0;
      err_set_s   = 1'b0;
      r_out_nxt_s = r_out_r;
      case (out_state_r)
         OUT_IDLE: begin
            // An acknowledge with no request outstanding is a consumer protocol violation
            if (a_out_s) begin
               err_set_s = 1'b1;
            end else begin
               err_set_s = 1'b0;
            end
            if (!empty_r) begin
               launch_s    = 1'b1;
               r_out_nxt_s = 1'b1;
               out_next_s  = OUT_REQ;
            end else begin
               r_out_nxt_s = 1'b0;
            end
         end
         OUT_REQ: begin
            if (a_out_s) begin
               pop_s       = 1'b1;
               r_out_nxt_s = 1'b0;
               out_next_s  = OUT_RTZ;
            end else begin
               r_out_nxt_s = 1'b1;
            end
         end
         OUT_RTZ: begin
            r_out_nxt_s = 1'b0;
            if (!a_out_s) begin
               out_next_s = OUT_IDLE;
            end else begin
               out_next_s = OUT_RTZ;
            end
         end
         default: begin
            r_out_nxt_s = 1'b0;
            out_next_s  = OUT_IDLE;
         end
      endcase
   end

   // Occupancy update; a same-edge push and pop cancel out
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Control state, pointers, occupancy flags and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_state_r  <= IN_IDLE;
         out_state_r <= OUT_IDLE;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         full_r      <= 1'b0;
         empty_r     <= 1'b1;
         a_in_r      <= 1'b0;
         r_out_r     <= 1'b0;
         d_out_r     <= '0;
         err_r       <= 1'b0;
      end else begin
         in_state_r  <= in_next_s;
         out_state_r <= out_next_s;
         a_in_r      <= a_in_nxt_s;
         r_out_r     <= r_out_nxt_s;
         count_r     <= count_nxt_s;
         full_r      <= (count_nxt_s == CW'(DEPTH));
         empty_r     <= (count_nxt_s == CW'(0));
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         if (launch_s) begin
            d_out_r <= mem_r[rd_ptr_r];
         end
         if (err_set_s) begin
            err_r <= 1'b1;
         end
      end
   end

   // Buffer storage; contents need no reset because occupancy guards every read
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= d_in;
      end
   end

   assign a_in  = a_in_r;
   assign r_out = r_out_r;
   assign d_out = d_out_r;
   assign count = count_r;
   assign full  = full_r;
   assign empty = empty_r;
   assign err   = err_r;

endmodule

// File: tb/tb_q_pipe_fifo.sv
// Scoreboard bench for q_pipe_fifo: a driver pushes accepted items into an expected
// queue, an independent consumer process pops and compares each presented item.
module tb_q_pipe_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             r_in = 1'b0;
   logic [WIDTH-1:0] d_in = 8'h00;
   logic             a_in;
   logic             r_out;
   logic [WIDTH-1:0] d_out;
   logic             a_out;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             err;

   logic             a_out_mon = 1'b0;
   logic             man_ack   = 1'b0;
   bit               cons_en   = 1'b0;
   int               mon_phase = 0;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [WIDTH-1:0] exp_q [$];

   assign a_out = cons_en ? a_out_mon : man_ack;

   q_pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .r_in  (r_in),
      .d_in  (d_in),
      .a_in  (a_in),
      .r_out (r_out),
      .d_out (d_out),
      .a_out (a_out),
      .count (count),
      .full  (full),
      .empty (empty),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_a_in(input logic v, input string nm);
      int n = 0;
      while (a_in !== v && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(nm, {31'd0, a_in}, {31'd0, v});
   endtask

   task automatic wait_r_out(input logic v, input string nm);
      int n = 0;
      while (r_out !== v && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(nm, {31'd0, r_out}, {31'd0, v});
   endtask

   // Four-phase producer: item becomes expected output once it has been acknowledged
   task automatic send(input logic [WIDTH-1:0] v);
      @(negedge clk);
      d_in = v;
      r_in = 1'b1;
      wait_a_in(1'b1, "send_ack_rise");
      exp_q.push_back(v);
      @(negedge clk);
      r_in = 1'b0;
      d_in = WIDTH'($urandom);
      wait_a_in(1'b0, "send_ack_fall");
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || mon_phase != 0 || r_out) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(nm, exp_q.size(), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // Consumer/monitor: randomly delayed acknowledge, compares against the expected queue
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            a_out_mon = 1'b0;
            mon_phase = 0;
         end else if (cons_en) begin
            if (mon_phase == 0) begin
               if (r_out && $urandom_range(0, 3) != 0) begin
                  chk("out_was_pushed", {31'd0, exp_q.size() != 0}, 32'd1);
                  if (exp_q.size() != 0) begin
                     chk("data_order", {24'd0, d_out}, {24'd0, exp_q.pop_front()});
                  end
                  a_out_mon = 1'b1;
                  mon_phase = 1;
               end
            end else if (!r_out) begin
               a_out_mon = 1'b0;
               mon_phase = 0;
            end
         end
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      n_fail++;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic stalled;
      int   n;

      // Reset with both request and acknowledge asserted
      rst     = 1'b0;
      r_in    = 1'b1;
      d_in    = 8'h3C;
      man_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_in",  {31'd0, a_in},  32'd0);
      chk("rst_r_out", {31'd0, r_out}, 32'd0);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full",  {31'd0, full},  32'd0);
      chk("rst_err",   {31'd0, err},   32'd0);
      chk("rst_d_out", {24'd0, d_out}, 32'd0);
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      wait_a_in(1'b1, "rst_release_ack");
      exp_q.push_back(8'h3C);
      @(negedge clk);
      r_in = 1'b0;
      wait_a_in(1'b0, "rst_release_ack_fall");
      cons_en = 1'b1;
      drain("rst_release_drain");
      cons_en = 1'b0;

      // Single transfer latency with the consumer under manual control
      @(negedge clk);
      d_in = 8'hA5;
      r_in = 1'b1;
      @(posedge clk);
      #1;
      chk("single_a_in",  {31'd0, a_in},  32'd1);
      chk("single_count", {29'd0, count}, 32'd1);
      chk("single_r_out_early", {31'd0, r_out}, 32'd0);
      @(negedge clk);
      r_in = 1'b0;
      d_in = 8'h00;
      @(posedge clk);
      #1;
      chk("single_r_out", {31'd0, r_out}, 32'd1);
      chk("single_d_out", {24'd0, d_out}, 32'h0000_00A5);
      chk("single_a_in_fall", {31'd0, a_in}, 32'd0);
      @(negedge clk);
      man_ack = 1'b1;
      @(posedge clk);
      #1;
      chk("single_r_out_fall", {31'd0, r_out}, 32'd0);
      chk("single_count_pop",  {29'd0, count}, 32'd0);
      chk("single_empty",      {31'd0, empty}, 32'd1);
      @(negedge clk);
      man_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("single_idle_r_out", {31'd0, r_out}, 32'd0);

      // Fill to DEPTH, stall the fifth request, release with one pop
      for (int i = 1; i <= 4; i++) send(WIDTH'(i));
      chk("fill_count", {29'd0, count}, 32'd4);
      chk("fill_full",  {31'd0, full},  32'd1);
      @(negedge clk);
      d_in = 8'h05;
      r_in = 1'b1;
      stalled = 1'b0;
      repeat (6) begin
         @(negedge clk);
         stalled = stalled | a_in;
      end
      chk("stall_a_in", {31'd0, stalled}, 32'd0);
      wait_r_out(1'b1, "stall_head_req");
      chk("stall_head_data", {24'd0, d_out}, {24'd0, exp_q.pop_front()});
      man_ack = 1'b1;
      wait_r_out(1'b0, "stall_pop");
      man_ack = 1'b0;
      wait_a_in(1'b1, "stall_release_ack");
      exp_q.push_back(8'h05);
      chk("stall_refill_count", {29'd0, count}, 32'd4);
      r_in = 1'b0;
      wait_a_in(1'b0, "stall_release_fall");
      cons_en = 1'b1;
      drain("fill_drain");
      chk("fill_drain_count", {29'd0, count}, 32'd0);

      // Ten items through the buffer to exercise pointer wrap
      for (int i = 0; i < 10; i++) begin
         send(8'h10 + WIDTH'(i));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain("wrap_drain");
      chk("wrap_count", {29'd0, count}, 32'd0);
      chk("wrap_empty", {31'd0, empty}, 32'd1);
      cons_en = 1'b0;

      // Push and pop on the same edge at occupancy two
      send(8'h41);
      send(8'h42);
      wait_r_out(1'b1, "simul_head_req");
      chk("simul_pre_count", {29'd0, count}, 32'd2);
      @(negedge clk);
      chk("simul_head_data", {24'd0, d_out}, {24'd0, exp_q.pop_front()});
      d_in    = 8'h43;
      r_in    = 1'b1;
      man_ack = 1'b1;
      @(posedge clk);
      #1;
      chk("simul_count", {29'd0, count}, 32'd2);
      chk("simul_a_in",  {31'd0, a_in},  32'd1);
      chk("simul_r_out", {31'd0, r_out}, 32'd0);
      exp_q.push_back(8'h43);
      @(negedge clk);
      r_in    = 1'b0;
      man_ack = 1'b0;
      wait_a_in(1'b0, "simul_ack_fall");
      cons_en = 1'b1;
      drain("simul_drain");
      chk("simul_drain_count", {29'd0, count}, 32'd0);

      // Randomised traffic
      n = 0;
      repeat (40) begin
         send(WIDTH'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         n++;
      end
      drain("rand_drain");
      chk("rand_count", {29'd0, count}, 32'd0);
      chk("rand_empty", {31'd0, empty}, 32'd1);
      chk("rand_err",   {31'd0, err},   32'd0);
      cons_en = 1'b0;

      // Acknowledge without a request sets the sticky error
      @(negedge clk);
      man_ack = 1'b1;
      @(posedge clk);
      #1;
      chk("err_set", {31'd0, err}, 32'd1);
      @(negedge clk);
      man_ack = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("err_sticky",  {31'd0, err},   32'd1);
      chk("err_r_out",   {31'd0, r_out}, 32'd0);
      chk("err_count",   {29'd0, count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("err_rst_clear", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
